vram_arbiter_m: RTL and testbench

VRAM_ARBITER_M -- requirements
Module: vram_arbiter_m

---
 rtl/vram_arbiter_m_pkg.sv | 25 ++
 rtl/sync_fifo_m.sv | 52 +++++
 rtl/vram_arbiter_m.sv | 104 ++++++++++
 tb/tb_vram_arbiter_m.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_m_pkg.sv
// Shared GPU definitions: VRAM geometry, arbiter state/grant encodings and defaults.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
`ifndef VRAM_SIZE
`define VRAM_SIZE 2048
`endif

package vram_arbiter_m_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned VRAM_AW            = `VRAM_ADDR_WIDTH;

    typedef enum logic {ST_CLOSED, ST_OPEN} arb_state_e;

    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_FILL} grant_e;

    // One extra bit so a VRAM_SIZE of exactly 2**VRAM_AW still compares correctly.
    function automatic logic in_vram(input logic [VRAM_AW-1:0] addr);
        logic [VRAM_AW:0] limit;
        limit = (VRAM_AW+1)'(`VRAM_SIZE);
        return {1'b0, addr} < limit;
    endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo_m #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter_m.sv
// VRAM write-port arbiter: buffered CPU writes and fill-engine writes share the port during vblank.
module vram_arbiter_m
    import vram_arbiter_m_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           write_window,
    input  logic                           cpu_valid,
    input  logic [`VRAM_ADDR_WIDTH-1:0]    cpu_address,
    input  logic [7:0]                     cpu_data,
    output logic                           cpu_ready,
    input  logic                           fill_valid,
    input  logic [`VRAM_ADDR_WIDTH-1:0]    fill_address,
    input  logic [7:0]                     fill_data,
    output logic                           fill_ready,
    output logic [`VRAM_ADDR_WIDTH-1:0]    vram_address,
    output logic [7:0]                     vram_data,
    output logic                           vram_write_enable,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    input  logic                           clear_overflow,
    output logic                           busy
);

    localparam int unsigned AW = `VRAM_ADDR_WIDTH;

    arb_state_e      state;
    grant_e          last_grant;
    grant_e          grant;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW+7:0]   fifo_head;
    logic            window_live;
    logic [AW-1:0]   gnt_address;
    logic [7:0]      gnt_data;

    assign cpu_ready   = !fifo_full;
    assign window_live = (state == ST_OPEN) && write_window;
    assign fill_ready  = (grant == GNT_FILL);
    assign busy        = (fifo_count != '0) || vram_write_enable;

    sync_fifo_m #(
        .WIDTH (AW + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_cpu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cpu_valid),
        .push_data ({cpu_address, cpu_data}),
        .pop       (grant == GNT_CPU),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        grant = GNT_NONE;
        if (window_live) begin
            if (!fifo_empty && fill_valid)
                grant = (last_grant == GNT_FILL) ? GNT_CPU : GNT_FILL;
            else if (!fifo_empty)
                grant = GNT_CPU;
            else if (fill_valid)
                grant = GNT_FILL;
        end
    end

    always_comb begin
        gnt_address = fill_address;
        gnt_data    = fill_data;
        if (grant == GNT_CPU) begin
            gnt_address = fifo_head[AW+7:8];
            gnt_data    = fifo_head[7:0];
        end
    end

    // Out-of-range grants are still consumed, but leave the port idle and its address/data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_CLOSED;
            last_grant        <= GNT_FILL;
            vram_write_enable <= 1'b0;
            vram_address      <= '0;
            vram_data         <= '0;
            overflow          <= 1'b0;
        end else begin
            state <= write_window ? ST_OPEN : ST_CLOSED;
            if (grant != GNT_NONE) last_grant <= grant;
            vram_write_enable <= (grant != GNT_NONE) && in_vram(gnt_address);
            if ((grant != GNT_NONE) && in_vram(gnt_address)) begin
                vram_address <= gnt_address;
                vram_data    <= gnt_data;
            end
            if (cpu_valid && !cpu_ready)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter_m.sv
// Directed-vector bench for vram_arbiter_m with hand-computed expectations.
module tb_vram_arbiter_m;

    logic                        clk;
    logic                        rst_n;
    logic                        write_window;
    logic                        cpu_valid;
    logic [`VRAM_ADDR_WIDTH-1:0] cpu_address;
    logic [7:0]                  cpu_data;
    logic                        cpu_ready;
    logic                        fill_valid;
    logic [`VRAM_ADDR_WIDTH-1:0] fill_address;
    logic [7:0]                  fill_data;
    logic                        fill_ready;
    logic [`VRAM_ADDR_WIDTH-1:0] vram_address;
    logic [7:0]                  vram_data;
    logic                        vram_write_enable;
    logic [2:0]                  fifo_count;
    logic                        overflow;
    logic                        clear_overflow;
    logic                        busy;

    int n_tests = 0;
    int n_fail  = 0;

    vram_arbiter_m #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_window      (write_window),
        .cpu_valid         (cpu_valid),
        .cpu_address       (cpu_address),
        .cpu_data          (cpu_data),
        .cpu_ready         (cpu_ready),
        .fill_valid        (fill_valid),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .fill_ready        (fill_ready),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_write_enable (vram_write_enable),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .clear_overflow    (clear_overflow),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_we"},   32'(vram_write_enable), 32'd1);
        check({tag, "_addr"}, 32'(vram_address), addr);
        check({tag, "_data"}, 32'(vram_data), data);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_we"}, 32'(vram_write_enable), 32'd0);
    endtask

    task automatic push_cpu(input logic [31:0] addr, input logic [31:0] data);
        cpu_valid   = 1'b1;
        cpu_address = `VRAM_ADDR_WIDTH'(addr);
        cpu_data    = 8'(data);
        tick();
        cpu_valid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; write_window = 1'b0; clear_overflow = 1'b0;
        cpu_valid = 1'b0; cpu_address = '0; cpu_data = '0;
        fill_valid = 1'b0; fill_address = '0; fill_data = '0;
        repeat (2) tick();
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        expect_idle("rst");
        check("rst_addr",  32'(vram_address), 32'd0);
        check("rst_data",  32'(vram_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Window closed: fill four entries, then overflow on the fifth.
        for (int i = 0; i < 4; i++) begin
            cpu_valid   = 1'b1;
            cpu_address = `VRAM_ADDR_WIDTH'(32'h100 + i);
            cpu_data    = 8'(32'hA0 + i);
            #1 check("fill_ready_cpu", 32'(cpu_ready), 32'd1);
            tick();
            expect_idle("closed");
            check("fill_count", 32'(fifo_count), 32'(i + 1));
        end
        cpu_address = `VRAM_ADDR_WIDTH'(32'h104);
        cpu_data    = 8'hA4;
        #1 check("full_ready", 32'(cpu_ready), 32'd0);
        tick();
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        clear_overflow = 1'b1;
        tick();
        check("ovf_wins_clear", 32'(overflow), 32'd1);
        cpu_valid = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        clear_overflow = 1'b0;

        // Drain: only the four accepted writes appear, in order.
        write_window = 1'b1;
        tick();
        expect_idle("drain_open");
        check("drain_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_write("drain", 32'h100 + i, 32'hA0 + i);
            check("drain_count", 32'(fifo_count), 32'(3 - i));
        end
        tick();
        expect_idle("drain_end");
        check("drain_busy_end", 32'(busy), 32'd0);
        write_window = 1'b0;
        tick();

        // Two buffered writes issue back to back once the window opens.
        push_cpu(32'h400, 32'h11);
        push_cpu(32'h401, 32'h22);
        write_window = 1'b1;
        tick();
        expect_idle("rise_lat");
        tick();
        expect_write("rise_w0", 32'h400, 32'h11);
        tick();
        expect_write("rise_w1", 32'h401, 32'h22);
        tick();
        expect_idle("rise_end");

        // A push into an empty FIFO while open is granted one cycle later.
        push_cpu(32'h402, 32'h33);
        expect_idle("nobypass");
        check("nobypass_count", 32'(fifo_count), 32'd1);
        tick();
        expect_write("nobypass_w", 32'h402, 32'h33);
        write_window = 1'b0;
        tick();

        // Reset mid-window with three entries buffered.
        push_cpu(32'h500, 32'h50);
        push_cpu(32'h501, 32'h51);
        push_cpu(32'h502, 32'h52);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        write_window = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf",   32'(overflow), 32'd0);
        expect_idle("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        expect_idle("post_rst1");
        tick();
        expect_idle("post_rst2");
        check("post_rst_count", 32'(fifo_count), 32'd0);
        write_window = 1'b0;
        tick();

        // Round-robin with both requesters valid; CPU wins first tie after reset.
        for (int i = 0; i < 4; i++) push_cpu(32'h010 + i, 32'hC0 + i);
        fill_valid   = 1'b1;
        fill_address = `VRAM_ADDR_WIDTH'(32'h200);
        fill_data    = 8'hF0;
        #1 check("closed_fill_ready", 32'(fill_ready), 32'd0);
        write_window = 1'b1;
        #1 check("closing_fill_ready", 32'(fill_ready), 32'd0);
        tick();
        expect_idle("rr_open");
        check("rr_fr0", 32'(fill_ready), 32'd0);
        tick();
        expect_write("rr_cpu0", 32'h010, 32'hC0);
        check("rr_fr1", 32'(fill_ready), 32'd1);
        tick();
        expect_write("rr_fill0", 32'h200, 32'hF0);
        check("rr_fr2", 32'(fill_ready), 32'd0);
        tick();
        expect_write("rr_cpu1", 32'h011, 32'hC1);
        tick();
        expect_write("rr_fill1", 32'h200, 32'hF0);
        fill_valid   = 1'b0;
        write_window = 1'b0;
        tick();
        expect_idle("rr_close");
        check("rr_count", 32'(fifo_count), 32'd2);

        // Window drops right after a grant: that write still issues, then nothing.
        write_window = 1'b1;
        tick();
        expect_idle("drop_open");
        tick();
        expect_write("drop_w", 32'h012, 32'hC2);
        write_window = 1'b0;
        tick();
        expect_idle("drop_idle1");
        check("drop_count", 32'(fifo_count), 32'd1);
        tick();
        expect_idle("drop_idle2");
        write_window = 1'b1;
        tick();
        expect_idle("reopen");
        tick();
        expect_write("reopen_w", 32'h013, 32'hC3);
        write_window = 1'b0;
        tick();
        expect_idle("reopen_end");
        check("reopen_count", 32'(fifo_count), 32'd0);

        // Out-of-range fill: acked, but the port stays idle and holds its last value.
        fill_valid   = 1'b1;
        fill_address = `VRAM_ADDR_WIDTH'(32'h900);
        fill_data    = 8'h55;
        write_window = 1'b1;
        #1 check("oor_closed_ready", 32'(fill_ready), 32'd0);
        tick();
        check("oor_ready", 32'(fill_ready), 32'd1);
        tick();
        expect_idle("oor");
        check("oor_addr_hold", 32'(vram_address), 32'h013);
        check("oor_data_hold", 32'(vram_data), 32'hC3);
        check("oor_busy", 32'(busy), 32'd0);
        fill_valid   = 1'b0;
        write_window = 1'b0;
        tick();
        expect_idle("oor_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
